// File: rtl/rca_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// rca_accumulator_pkg
// Shared definitions for the streaming ripple-carry accumulator:
//   - state_e      : accumulator FSM states (ACCUM collects beats, HOLD
//                    presents the packet result until it is taken)
//   - DEF_*_BITS   : default widths for the operand, accumulator and counter
// -----------------------------------------------------------------------------
package rca_accumulator_pkg;

  localparam int DEF_BITS       = 8;
  localparam int DEF_ACC_BITS   = 16;
  localparam int DEF_COUNT_BITS = 8;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

endpackage : rca_accumulator_pkg

// File: rtl/rca_accumulator_if.sv
// -----------------------------------------------------------------------------
// rca_accumulator_if
// Input stream and result bus of the accumulator.
//   in_valid/in_ready/in_data/in_last  : operand stream, one beat per handshake
//   out_valid/out_ready                : result handshake, one beat per packet
//   out_sum/out_count/out_overflow     : packet total, beat count, carry flag
// Modports:
//   slave  : the accumulator (consumes operands, produces the result)
//   master : the environment (produces operands, consumes the result)
// -----------------------------------------------------------------------------
interface rca_accumulator_if
  import rca_accumulator_pkg::*;
#(
  parameter int BITS       = DEF_BITS,
  parameter int ACC_BITS   = DEF_ACC_BITS,
  parameter int COUNT_BITS = DEF_COUNT_BITS
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [BITS-1:0]       in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_BITS-1:0]   out_sum;
  logic [COUNT_BITS-1:0] out_count;
  logic                  out_overflow;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_overflow
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_overflow
  );

endinterface : rca_accumulator_if

// File: rtl/rca_accumulator_rca.sv
// -----------------------------------------------------------------------------
// rca_accumulator_rca
// Parameterized ripple-carry adder: a chain of BITS full adders.
// Ports:
//   a_i, b_i  : operands (BITS wide)
//   cin_i     : carry into bit 0
//   sum_o     : a_i + b_i + cin_i, modulo 2^BITS
//   cout_o    : carry out of the most significant bit
// -----------------------------------------------------------------------------
module rca_accumulator_rca #(
  parameter int BITS = 16
) (
  input  logic [BITS-1:0] a_i,
  input  logic [BITS-1:0] b_i,
  input  logic            cin_i,
  output logic [BITS-1:0] sum_o,
  output logic            cout_o
);

  logic [BITS:0]   carry_s;
  logic [BITS-1:0] sum_s;

  // Full-adder chain; carry_s[i] is the carry into bit i.
  always_comb begin
    carry_s    = {(BITS+1){1'b0}};
    sum_s      = {BITS{1'b0}};
    carry_s[0] = cin_i;
    for (int i = 0; i < BITS; i++) begin
      sum_s[i]     = a_i[i] ^ b_i[i] ^ carry_s[i];
      carry_s[i+1] = (a_i[i] & b_i[i]) | (carry_s[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign sum_o  = sum_s;
  assign cout_o = carry_s[BITS];

endmodule : rca_accumulator_rca

// File: rtl/rca_accumulator.sv
// -----------------------------------------------------------------------------
// rca_accumulator
// Sums a packet of unsigned BITS-wide operands into an ACC_BITS-wide total
// using the ripple-carry adder, and emits one registered result per packet.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (drops any partial or pending packet)
//   bus  : slave side of rca_accumulator_if (operand stream + result beat)
// Behaviour:
//   ACCUM : in_ready=1; each handshake adds the operand, bumps the saturating
//           beat counter and ORs the adder carry into the sticky overflow.
//           A beat with in_last moves to HOLD.
//   HOLD  : out_valid=1 with the totals held steady; out_ready clears the
//           totals and returns to ACCUM.
// All outputs come straight from registers or the state register.
// -----------------------------------------------------------------------------
module rca_accumulator
  import rca_accumulator_pkg::*;
#(
  parameter int BITS       = DEF_BITS,
  parameter int ACC_BITS   = DEF_ACC_BITS,
  parameter int COUNT_BITS = DEF_COUNT_BITS
) (
  input  logic               clk,
  input  logic               rst,
  rca_accumulator_if.slave   bus
);

  localparam logic [COUNT_BITS-1:0] COUNT_MAX = {COUNT_BITS{1'b1}};

  state_e                state_q, state_d;
  logic [ACC_BITS-1:0]   acc_q,   acc_d;
  logic [COUNT_BITS-1:0] count_q, count_d;
  logic                  ovf_q,   ovf_d;

  logic [ACC_BITS-1:0]   operand_s;
  logic [ACC_BITS-1:0]   add_sum_s;
  logic                  add_cout_s;
  logic                  in_hs_s;

  // Operand is zero-extended to the accumulator width.
  assign operand_s = ACC_BITS'(bus.in_data);

  rca_accumulator_rca #(
    .BITS (ACC_BITS)
  ) u_rca (
    .a_i    (acc_q),
    .b_i    (operand_s),
    .cin_i  (1'b0),
    .sum_o  (add_sum_s),
    .cout_o (add_cout_s)
  );

  assign in_hs_s = bus.in_valid & (state_q == ACCUM);

  // Next-state logic for the FSM, accumulator, beat counter and sticky flag.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      ACCUM: begin
        if (in_hs_s) begin
          acc_d = add_sum_s;
          ovf_d = ovf_q | add_cout_s;
          // Counter saturates instead of wrapping on very long packets.
          if (count_q != COUNT_MAX) begin
            count_d = count_q + COUNT_BITS'(1);
          end else begin
            count_d = count_q;
          end
          if (bus.in_last) begin
            state_d = HOLD;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = ACCUM;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = ACCUM;
          acc_d   = {ACC_BITS{1'b0}};
          count_d = {COUNT_BITS{1'b0}};
          ovf_d   = 1'b0;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = ACCUM;
        acc_d   = {ACC_BITS{1'b0}};
        count_d = {COUNT_BITS{1'b0}};
        ovf_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= {ACC_BITS{1'b0}};
      count_q <= {COUNT_BITS{1'b0}};
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready     = (state_q == ACCUM);
  assign bus.out_valid    = (state_q == HOLD);
  assign bus.out_sum      = acc_q;
  assign bus.out_count    = count_q;
  assign bus.out_overflow = ovf_q;

endmodule : rca_accumulator

// File: tb/tb_rca_accumulator.sv
// -----------------------------------------------------------------------------
// tb_rca_accumulator
// Directed testbench for rca_accumulator. Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_rca_accumulator;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_mis;

  rca_accumulator_if #(.BITS(8), .ACC_BITS(16), .COUNT_BITS(8)) bus ();

  rca_accumulator #(
    .BITS       (8),
    .ACC_BITS   (16),
    .COUNT_BITS (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for exactly one rising edge, then drop in_valid.
  task automatic send_beat(input logic [7:0] data, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_last  = last;
    step();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Compare all outputs against expected values at the next falling edge.
  task automatic check_out(input string name, input logic exp_ready,
                           input logic exp_valid, input logic [15:0] exp_sum,
                           input logic [7:0] exp_cnt, input logic exp_ovf);
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== exp_ready || bus.out_valid !== exp_valid ||
        bus.out_sum !== exp_sum || bus.out_count !== exp_cnt ||
        bus.out_overflow !== exp_ovf) begin
      n_mis++;
      $display("FAIL %s: got rdy=%b vld=%b sum=%0d cnt=%0d ovf=%b, expected rdy=%b vld=%b sum=%0d cnt=%0d ovf=%b",
               name, bus.in_ready, bus.out_valid, bus.out_sum, bus.out_count,
               bus.out_overflow, exp_ready, exp_valid, exp_sum, exp_cnt, exp_ovf);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'd0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    check_out("reset", 1'b1, 1'b0, 16'd0, 8'd0, 1'b0);
    #1;
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    send_beat(8'd3, 1'b0);
    check_out("basic_partial", 1'b1, 1'b0, 16'd3, 8'd1, 1'b0);
    #1;
    send_beat(8'd5, 1'b0);
    send_beat(8'd7, 1'b1);
    check_out("basic_result", 1'b0, 1'b1, 16'd15, 8'd3, 1'b0);
    #1;
    step();
    check_out("basic_cleared", 1'b1, 1'b0, 16'd0, 8'd0, 1'b0);
    #1;
  endtask

  task automatic test_saturate();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 299; i++) begin
      send_beat(8'hFF, 1'b0);
    end
    check_out("sat_before_last", 1'b1, 1'b0, 16'd10709, 8'd255, 1'b1);
    #1;
    send_beat(8'hFF, 1'b1);
    check_out("sat_result", 1'b0, 1'b1, 16'd10964, 8'd255, 1'b1);
    #1;
  endtask

  task automatic test_backpressure();
    // Result from test_saturate is still pending with out_ready low.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd9;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_out("bp_hold", 1'b0, 1'b1, 16'd10964, 8'd255, 1'b1);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check_out("bp_release", 1'b1, 1'b0, 16'd0, 8'd0, 1'b0);
    #1;
    bus.out_ready = 1'b0;
    send_beat(8'd1, 1'b1);
    check_out("bp_next_packet", 1'b0, 1'b1, 16'd1, 8'd1, 1'b0);
    #1;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_single_beat();
    send_beat(8'd0, 1'b1);
    check_out("single_zero", 1'b0, 1'b1, 16'd0, 8'd1, 1'b0);
    #1;
    bus.out_ready = 1'b1;
    step();
    check_out("single_cleared", 1'b1, 1'b0, 16'd0, 8'd0, 1'b0);
    #1;
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    send_beat(8'd10, 1'b0);
    send_beat(8'd20, 1'b0);
    check_out("mid_partial", 1'b1, 1'b0, 16'd30, 8'd2, 1'b0);
    #1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_out("mid_after_rst", 1'b1, 1'b0, 16'd0, 8'd0, 1'b0);
    #1;
    send_beat(8'd4, 1'b1);
    check_out("mid_result", 1'b0, 1'b1, 16'd4, 8'd1, 1'b0);
    #1;
    // Reset while a result is pending drops it.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_out("hold_rst", 1'b1, 1'b0, 16'd0, 8'd0, 1'b0);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst   = 1'b1;
    test_reset();
    test_basic();
    test_saturate();
    test_backpressure();
    test_single_beat();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_rca_accumulator

// File: doc/rca_accumulator.md
# rca_accumulator

Streaming accumulator that sums a packet of unsigned `BITS`-wide operands into an `ACC_BITS`-wide total. It uses the team's parameterized ripple-carry adder as its datapath and registers the total around it. Input is valid/ready, terminated by `in_last`. Output is one registered result beat per packet, carrying the sum, beat count and sticky overflow, held under backpressure.

## Interface
- `BITS`, 8: width of each input operand.
- `ACC_BITS`, 16: accumulator and result width; must be ≥ `BITS`.
- `COUNT_BITS`, 8: width of the per-packet beat counter.

- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operand beat present.
- `in_ready` output 1: block accepts a beat this cycle.
- `in_data` input `BITS`: unsigned operand.
- `in_last` input 1: beat is the final beat of the packet.
- `out_valid` output 1: result beat present.
- `out_ready` input 1: downstream accepts the result.
- `out_sum` output `ACC_BITS`: packet total, modulo 2^`ACC_BITS`.
- `out_count` output `COUNT_BITS`: number of accepted beats, saturating.
- `out_overflow` output 1: at least one addition in the packet produced a carry-out.

## Operation
- The FSM has two states: `ACCUM` and `HOLD`. Reset state is `ACCUM`.
- `ACCUM`:
  - `in_ready`=1 and `out_valid`=0.
  - A handshake occurs when `in_valid` & `in_ready`.
  - On a handshake: `acc <= acc + zext(in_data)` via the adder, with `cin`=0 and width `ACC_BITS`. `ovf <= ovf | cout`. `count <= count + 1`, saturating at 2^`COUNT_BITS`−1 (no wrap).
  - If `in_last` is set on the handshake, go to `HOLD`. The beat's contribution is included in the result.
- `HOLD`:
  - `in_ready`=0 and `out_valid`=1. `in_valid` is ignored, with no state change.
  - `out_sum`/`out_count`/`out_overflow` present `acc`/`count`/`ovf` and are stable while `out_ready`=0.
  - On `out_ready`=1: clear `acc`, `count` and `ovf` to 0 and return to `ACCUM`.
- The sum wraps modulo 2^`ACC_BITS`. Overflow is sticky for the packet and is cleared only on result handoff or reset.
- A packet may be one beat long (`in_last` on the first beat).
- `rst` in any state discards a partial packet or a pending result. It forces `ACCUM` and zeroes all registers.

## Timing
- Reset values: `in_ready`=1 (from the first cycle after `rst` deasserts), `out_valid`=0, `out_sum`=0, `out_count`=0, `out_overflow`=0.
- Latency: `out_valid` rises the cycle after the handshake carrying `in_last`.
- Throughput:
  - One beat per cycle within a packet.
  - At least one dead cycle per packet: `in_ready`=0 in `HOLD`.
  - `in_ready` returns to 1 the cycle after the output handshake.
- All outputs are registered or decoded directly from state. There is no combinational path from `in_*` or `out_ready` to any output.
- Adder critical path: `ACC_BITS` full-adder carry chain, in a single cycle.

## Structure
- The shared package holds the FSM state enum (`ACCUM`, `HOLD`) and the default width constants.
- One sub-module: the existing parameterized ripple-carry adder `RCA`.
  - Instantiated with `BITS`=`ACC_BITS` and `cin`=0.
  - Operands: `acc` and `{ {(ACC_BITS-BITS){1'b0}}, in_data }`.
- Counter, sticky flag and FSM are in this module.

## Test plan
- Reset: hold `rst` 3 cycles, release → `in_ready`=1, `out_valid`=0, all result outputs 0.
- Beats 3, 5, 7 (`last` on 7), `out_ready`=1 → next cycle `out_valid`=1, `out_sum`=15, `out_count`=3, `out_overflow`=0. The following cycle `in_ready`=1 and the registers are cleared.
- 300 beats of 0xFF, `last` on the 300th → `out_sum`=10964 (76500 mod 65536), `out_overflow`=1, `out_count`=255 (saturated).
- Backpressure: after a result, hold `out_ready`=0 for 5 cycles with `in_valid`=1 and `in_data`=9 → outputs unchanged, `in_ready`=0, no beat absorbed. Raise `out_ready` → `in_ready`=1 next cycle, and the next packet starts from 0.
- Single-beat packet `in_data`=0 with `last` → `out_sum`=0, `out_count`=1, `out_overflow`=0.
- Reset mid-packet: accept 10, 20, then pulse `rst`; send 4 with `last` → `out_sum`=4, `out_count`=1.
